// File: rtl/nes_poll_scheduler.sv
// Purpose: sequences the NES controller interface and turns fetch results into a button snapshot plus pressed/released edge masks.
// Latency: start_fetch_o is high one cycle after a tick or request seen in IDLE; outputs update one cycle after the valid rising edge.
// Backpressure: none. A tick that arrives while a fetch is in flight is dropped and flagged on overrun_o. A request is held until poll_ack_o.
//
// Ports:
//   clk, rst_ni        clock, asynchronous active-low reset
//   enable_i           periodic polling enable
//   poll_req_i         host fetch request (level, held until poll_ack_o)
//   poll_ack_o         pulse when the fetch serving the request completes or aborts
//   start_fetch_o      pulse to the interface start input
//   fetch_valid_i      interface valid level
//   fetch_data_i       interface data, controller 1 in the MSBs
//   buttons_o          last good snapshot (1 = pressed)
//   pressed_o          bits newly pressed at the last update
//   released_o         bits newly released at the last update
//   update_o           pulse when buttons_o, pressed_o and released_o change
//   overrun_o          sticky flag: a periodic tick was dropped
//   timeout_o          sticky flag: the watchdog aborted a fetch
//   clear_i            clears both sticky flags
module nes_poll_scheduler #(
    parameter int NUM_CONTROLLERS = 4,
    parameter int POLL_PERIOD     = 100000,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         poll_req_i,
    output logic                         poll_ack_o,
    output logic                         start_fetch_o,
    input  logic                         fetch_valid_i,
    input  logic [8*NUM_CONTROLLERS-1:0] fetch_data_i,
    output logic [8*NUM_CONTROLLERS-1:0] buttons_o,
    output logic [8*NUM_CONTROLLERS-1:0] pressed_o,
    output logic [8*NUM_CONTROLLERS-1:0] released_o,
    output logic                         update_o,
    output logic                         overrun_o,
    output logic                         timeout_o,
    input  logic                         clear_i
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q;
    logic [TW-1:0] tcnt_q;
    logic          vld_q;
    logic          req_pending_q;

    logic tick;
    logic valid_rise;
    logic launch;
    logic done_ok;
    logic done_to;

    assign tick       = enable_i && (pcnt_q == P_LAST);
    // Only a fresh rising edge completes a fetch. A valid level left high
    // from the previous fetch must not complete the current one.
    assign valid_rise = fetch_valid_i && !vld_q;

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick || poll_req_i) begin
                    launch  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // If completion and timeout happen in the same cycle, completion wins.
                if (valid_rise) begin
                    done_ok = 1'b1;
                    state_d = ST_IDLE;
                end else if (tcnt_q == T_LAST) begin
                    done_to = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q        <= '0;
            tcnt_q        <= '0;
            vld_q         <= 1'b0;
            req_pending_q <= 1'b0;
            poll_ack_o    <= 1'b0;
            start_fetch_o <= 1'b0;
            buttons_o     <= '0;
            pressed_o     <= '0;
            released_o    <= '0;
            update_o      <= 1'b0;
            overrun_o     <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            // The period counter runs independently of the FSM, so a dropped
            // tick does not shift the phase of later ticks.
            if (!enable_i || pcnt_q == P_LAST) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + PW'(1);
            end

            if (state_q == ST_START) begin
                tcnt_q <= '0;
            end else if (state_q == ST_WAIT && tcnt_q != T_LAST) begin
                tcnt_q <= tcnt_q + TW'(1);
            end

            vld_q <= fetch_valid_i;

            if (launch) begin
                req_pending_q <= poll_req_i;
            end

            start_fetch_o <= launch;
            update_o      <= done_ok;
            poll_ack_o    <= (done_ok || done_to) && req_pending_q;

            if (done_ok) begin
                buttons_o  <= fetch_data_i;
                pressed_o  <= fetch_data_i & ~buttons_o;
                released_o <= ~fetch_data_i & buttons_o;
            end

            // If clear_i and a new set event happen in the same cycle, the flag stays set.
            overrun_o <= (overrun_o && !clear_i) || (tick && state_q != ST_IDLE);
            timeout_o <= (timeout_o && !clear_i) || done_to;
        end
    end

endmodule
